hilo_ctrl: RTL and testbench

- Sequencer and result store sitting directly downstream of the iterative divider and the multiplier in the multicycle datapath.
- Takes a div/mult request from the control unit and issues the single-cycle start pulse to the selected unit.
- Waits for that unit's completion, handles divide-by-zero and timeout, and commits the 64-bit result into the architectural HI/LO registers.
- Serves MTHI/MTLO writes and presents HI/LO to the MFHI/MFLO datapath mux.

---
 rtl/hilo_ctrl_if.sv | 43 ++++
 rtl/hilo_ctrl.sv | 158 +++++++++++++++
 tb/tb_hilo_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_ctrl_if.sv
// Signal bundle between the control unit / divider / multiplier side and hilo_ctrl.
// The slave modport is the hilo_ctrl view; master is the surrounding datapath view.
interface hilo_ctrl_if;
  logic        start_div;
  logic        start_mult;
  logic        div_stop;
  logic        div_zero;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        mult_stop;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] wdata;
  logic        div_control;
  logic        mult_control;
  logic        busy;
  logic        done;
  logic        exc_div_zero;
  logic        exc_timeout;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [2:0]  dbg_state;

  modport slave (
    input  start_div, start_mult,
    input  div_stop, div_zero, div_hi, div_lo,
    input  mult_stop, mult_hi, mult_lo,
    input  hi_write, lo_write, wdata,
    output div_control, mult_control, busy, done,
    output exc_div_zero, exc_timeout, hi, lo, dbg_state
  );

  modport master (
    output start_div, start_mult,
    output div_stop, div_zero, div_hi, div_lo,
    output mult_stop, mult_hi, mult_lo,
    output hi_write, lo_write, wdata,
    input  div_control, mult_control, busy, done,
    input  exc_div_zero, exc_timeout, hi, lo, dbg_state
  );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: launches the divider or multiplier, waits for completion with a
// timeout, commits the 64-bit result to HI/LO, and serves MTHI/MTLO writes when idle.
module hilo_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input logic       clk,
  input logic       reset,
  hilo_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_DIV_START  = 3'd1;
  localparam logic [2:0] S_DIV_WAIT   = 3'd2;
  localparam logic [2:0] S_MULT_START = 3'd3;
  localparam logic [2:0] S_MULT_WAIT  = 3'd4;
  localparam logic [2:0] S_COMMIT     = 3'd5;
  localparam logic [2:0] S_EXC        = 3'd6;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_res_hi;
  logic [31:0]      r_res_lo;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_div_control;
  logic             r_mult_control;
  logic             r_busy;
  logic             r_done;
  logic             r_exc_div_zero;
  logic             r_exc_timeout;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_zero_hit;
  logic             w_cap_div;
  logic             w_cap_mult;
  logic             w_busy_nxt;

  // Next-state logic. Within a WAIT state the priority is zero, then stop, then timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_zero_hit  = 1'b0;
    w_cap_div   = 1'b0;
    w_cap_mult  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_div) begin
          w_state_nxt = S_DIV_START;
        end else if (bus.start_mult) begin
          w_state_nxt = S_MULT_START;
        end
      end
      S_DIV_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        if (bus.div_zero) begin
          w_zero_hit  = 1'b1;
          w_state_nxt = S_EXC;
        end else if (bus.div_stop) begin
          w_cap_div   = 1'b1;
          w_state_nxt = S_COMMIT;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = S_EXC;
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      S_MULT_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_MULT_WAIT;
      end
      S_MULT_WAIT: begin
        if (bus.mult_stop) begin
          w_cap_mult  = 1'b1;
          w_state_nxt = S_COMMIT;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = S_EXC;
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      S_COMMIT: w_state_nxt = S_IDLE;
      S_EXC:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_busy_nxt = (w_state_nxt == S_DIV_START)  || (w_state_nxt == S_DIV_WAIT) ||
                      (w_state_nxt == S_MULT_START) || (w_state_nxt == S_MULT_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_div_control  <= 1'b0;
      r_mult_control <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_exc_div_zero <= 1'b0;
      r_exc_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_div_control  <= (w_state_nxt == S_DIV_START);
      r_mult_control <= (w_state_nxt == S_MULT_START);
      r_busy         <= w_busy_nxt;
      r_done         <= (w_state_nxt == S_COMMIT);
      r_exc_div_zero <= (w_state_nxt == S_EXC) && w_zero_hit;
      r_exc_timeout  <= (w_state_nxt == S_EXC) && !w_zero_hit;
    end
  end

  // The completing unit's result is held here until COMMIT writes it to HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else if (w_cap_div) begin
      r_res_hi <= bus.div_hi;
      r_res_lo <= bus.div_lo;
    end else if (w_cap_mult) begin
      r_res_hi <= bus.mult_hi;
      r_res_lo <= bus.mult_lo;
    end
  end

  // Architectural HI/LO: MTHI/MTLO only while idle, otherwise only the COMMIT update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_IDLE) begin
      if (bus.hi_write) r_hi <= bus.wdata;
      if (bus.lo_write) r_lo <= bus.wdata;
    end else if (r_state == S_COMMIT) begin
      r_hi <= r_res_hi;
      r_lo <= r_res_lo;
    end
  end

  assign bus.div_control  = r_div_control;
  assign bus.mult_control = r_mult_control;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.exc_div_zero = r_exc_div_zero;
  assign bus.exc_timeout  = r_exc_timeout;
  assign bus.hi           = r_hi;
  assign bus.lo           = r_lo;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with behavioural divider/multiplier models and a
// scoreboard that checks every done/exception event and the HI/LO that follows it.
module tb_hilo_ctrl;

  localparam int TIMEOUT  = 40;
  localparam int DIV_LAT  = 33;
  localparam int MULT_LAT = 4;
  localparam int W        = 67;

  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_ZERO = 3'b010;
  localparam logic [2:0] K_TO   = 3'b100;

  logic clk;
  logic reset;
  hilo_ctrl_if bus();

  hilo_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  int div_mode  = 0;   // 0 normal, 1 divisor zero, 2 never finishes
  int mult_mode = 0;   // 0 normal, 2 never finishes
  int div_cnt;
  int mult_cnt;
  int n_divc  = 0;
  int n_multc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // divider model: clears flags on start, raises div_stop DIV_LAT edges later
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.div_stop <= 1'b0;
      bus.div_zero <= 1'b0;
      div_cnt      <= 0;
    end else if (bus.div_control) begin
      bus.div_stop <= 1'b0;
      bus.div_zero <= (div_mode == 1);
      div_cnt      <= (div_mode == 0) ? DIV_LAT : 0;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) bus.div_stop <= 1'b1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mult_stop <= 1'b0;
      mult_cnt      <= 0;
    end else if (bus.mult_control) begin
      bus.mult_stop <= 1'b0;
      mult_cnt      <= (mult_mode == 0) ? MULT_LAT : 0;
    end else if (mult_cnt > 0) begin
      mult_cnt <= mult_cnt - 1;
      if (mult_cnt == 1) bus.mult_stop <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (bus.div_control)  n_divc  <= n_divc + 1;
    if (bus.mult_control) n_multc <= n_multc + 1;
  end

  // monitor: pop on each event, compare kind now and HI/LO one cycle later
  initial begin
    logic [W-1:0] e;
    logic [2:0]   kind;
    bit           pend;
    logic [31:0]  p_hi;
    logic [31:0]  p_lo;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && !reset) begin
        check("commit_hi", {32'b0, bus.hi}, {32'b0, p_hi});
        check("commit_lo", {32'b0, bus.lo}, {32'b0, p_lo});
      end
      pend = 1'b0;
      kind = {bus.exc_timeout, bus.exc_div_zero, bus.done};
      if (!reset && kind != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {61'b0, kind}, 64'b0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {61'b0, kind}, {61'b0, e[66:64]});
          p_hi = e[63:32];
          p_lo = e[31:0];
          pend = 1'b1;
        end
      end
    end
  end

  // drivers
  task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
    @(negedge clk);
    bus.hi_write = wh;
    bus.lo_write = wl;
    bus.wdata    = d;
    @(negedge clk);
    bus.hi_write = 1'b0;
    bus.lo_write = 1'b0;
  endtask

  task automatic do_op(input string nm, input bit is_div, input int mode, input bit both,
                       input bit poke, input logic [2:0] kind, input logic [31:0] ehi,
                       input logic [31:0] elo, input int elat);
    int d0;
    int m0;
    int cnt;
    bit busy_bad;
    d0 = n_divc;
    m0 = n_multc;
    busy_bad = 1'b0;
    exp_q.push_back({kind, ehi, elo});
    @(negedge clk);
    if (is_div) begin
      div_mode       = mode;
      bus.start_div  = 1'b1;
      bus.start_mult = both;
    end else begin
      mult_mode      = mode;
      bus.start_mult = 1'b1;
    end
    @(negedge clk);
    bus.start_div  = 1'b0;
    bus.start_mult = 1'b0;
    check({nm, "_start_pulse"}, {63'b0, is_div ? bus.div_control : bus.mult_control}, 64'd1);
    cnt = 0;
    while (!(bus.done || bus.exc_div_zero || bus.exc_timeout) && cnt < 200) begin
      if (!bus.busy) busy_bad = 1'b1;
      if (poke && cnt == 10) begin
        bus.hi_write   = 1'b1;
        bus.wdata      = 32'hDEAD_BEEF;
        bus.start_mult = 1'b1;
      end else begin
        bus.hi_write   = 1'b0;
        bus.start_mult = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    bus.hi_write   = 1'b0;
    bus.start_mult = 1'b0;
    check({nm, "_latency"}, 64'(cnt), 64'(elat));
    check({nm, "_busy_held"}, {63'b0, busy_bad}, 64'd0);
    check({nm, "_busy_end"}, {63'b0, bus.busy}, 64'd0);
    @(negedge clk);
    check({nm, "_div_pulses"}, 64'(n_divc - d0), is_div ? 64'd1 : 64'd0);
    check({nm, "_mult_pulses"}, 64'(n_multc - m0), is_div ? 64'd0 : 64'd1);
    check({nm, "_idle"}, {61'b0, bus.dbg_state}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.start_div  = 1'b0;
    bus.start_mult = 1'b0;
    bus.div_hi     = '0;
    bus.div_lo     = '0;
    bus.mult_hi    = '0;
    bus.mult_lo    = '0;
    bus.hi_write   = 1'b0;
    bus.lo_write   = 1'b0;
    bus.wdata      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_hi",    {32'b0, bus.hi}, 64'd0);
    check("rst_lo",    {32'b0, bus.lo}, 64'd0);
    check("rst_busy",  {63'b0, bus.busy}, 64'd0);
    check("rst_done",  {63'b0, bus.done}, 64'd0);
    check("rst_excz",  {63'b0, bus.exc_div_zero}, 64'd0);
    check("rst_exct",  {63'b0, bus.exc_timeout}, 64'd0);
    check("rst_divc",  {63'b0, bus.div_control}, 64'd0);
    check("rst_multc", {63'b0, bus.mult_control}, 64'd0);
    check("rst_state", {61'b0, bus.dbg_state}, 64'd0);

    mt_write(1'b0, 1'b1, 32'h0000_1234);
    check("mtlo_lo", {32'b0, bus.lo}, 64'h1234);
    check("mtlo_hi", {32'b0, bus.hi}, 64'h0);
    mt_write(1'b1, 1'b1, 32'h5555_0000);
    check("mtboth_hi", {32'b0, bus.hi}, 64'h5555_0000);
    check("mtboth_lo", {32'b0, bus.lo}, 64'h5555_0000);

    // 7 / 2: remainder 1, quotient 3
    bus.div_hi = 32'd1;
    bus.div_lo = 32'd3;
    do_op("div7_2", 1'b1, 0, 1'b0, 1'b0, K_DONE, 32'd1, 32'd3, 35);

    mt_write(1'b1, 1'b0, 32'hAAAA_AAAA);
    check("mthi_hi", {32'b0, bus.hi}, 64'hAAAA_AAAA);
    do_op("divzero", 1'b1, 1, 1'b0, 1'b0, K_ZERO, 32'hAAAA_AAAA, 32'd3, 2);
    do_op("divto", 1'b1, 2, 1'b0, 1'b0, K_TO, 32'hAAAA_AAAA, 32'd3, TIMEOUT + 1);

    bus.mult_hi = 32'h1234_5678;
    bus.mult_lo = 32'h9ABC_DEF0;
    do_op("mult", 1'b0, 0, 1'b0, 1'b0, K_DONE, 32'h1234_5678, 32'h9ABC_DEF0, 2 + MULT_LAT);
    do_op("multto", 1'b0, 2, 1'b0, 1'b0, K_TO, 32'h1234_5678, 32'h9ABC_DEF0, TIMEOUT + 1);

    bus.div_hi = 32'h11;
    bus.div_lo = 32'h22;
    do_op("arb", 1'b1, 0, 1'b1, 1'b0, K_DONE, 32'h11, 32'h22, 35);

    bus.div_hi = 32'h33;
    bus.div_lo = 32'h44;
    do_op("busy_ign", 1'b1, 0, 1'b0, 1'b1, K_DONE, 32'h33, 32'h44, 35);

    // reset in DIV_WAIT cycle 10
    @(negedge clk);
    div_mode      = 0;
    bus.start_div = 1'b1;
    @(negedge clk);
    bus.start_div = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_state_wait", {61'b0, bus.dbg_state}, 64'd2);
    reset = 1'b1;
    #1;
    check("midrst_hi",    {32'b0, bus.hi}, 64'd0);
    check("midrst_lo",    {32'b0, bus.lo}, 64'd0);
    check("midrst_busy",  {63'b0, bus.busy}, 64'd0);
    check("midrst_state", {61'b0, bus.dbg_state}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.div_hi = 32'd5;
    bus.div_lo = 32'd6;
    do_op("after_rst", 1'b1, 0, 1'b0, 1'b0, K_DONE, 32'd5, 32'd6, 35);

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
